// File: rtl/rram_seq_ctrl.sv
// Sequencing controller for the RRAM cache/counter datapath: accepts host
// commands, drives counter strobes, waits for completion flags with a watchdog.
module rram_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int TW             = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_form,
    input  logic cmd_write,
    input  logic cmd_read,
    input  logic cmd_release,
    input  logic forming_count_flag,
    input  logic write_count_flag,
    input  logic cache_count_flag,
    output logic en,
    output logic forming,
    output logic we,
    output logic re,
    output logic WE_L,
    output logic RE_L,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FORM, S_WRITE, S_READ, S_OUT, S_FIN, S_ERR
    } state_t;

    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] wd;
    logic          err_q;
    logic          timeout;

    assign timeout = (wd == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Watchdog restarts on every state change and only runs while
            // waiting for a counter flag.
            if (state_nxt != state)
                wd <= '0;
            else if (state == S_FORM || state == S_WRITE || state == S_READ)
                wd <= wd + TW'(1);
            if (state_nxt == S_ERR)
                err_q <= 1'b1;
            else if (state == S_IDLE && state_nxt != S_IDLE)
                err_q <= 1'b0;
        end
    end

    // Matching flag takes precedence over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_form)       state_nxt = S_FORM;
                else if (cmd_write) state_nxt = S_WRITE;
                else if (cmd_read)  state_nxt = S_READ;
            end
            S_FORM: begin
                if (forming_count_flag) state_nxt = S_FIN;
                else if (timeout)       state_nxt = S_ERR;
            end
            S_WRITE: begin
                if (write_count_flag) state_nxt = S_FIN;
                else if (timeout)     state_nxt = S_ERR;
            end
            S_READ: begin
                if (cache_count_flag) state_nxt = S_OUT;
                else if (timeout)     state_nxt = S_ERR;
            end
            S_OUT: begin
                if (cmd_release) state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign en      = (state != S_IDLE) && (state != S_ERR);
    assign forming = (state == S_FORM);
    assign we      = (state == S_WRITE);
    assign re      = (state == S_READ);
    assign WE_L    = (state == S_READ);
    assign RE_L    = (state == S_OUT);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FIN);
    assign err     = err_q;

endmodule

// File: tb/tb_rram_seq_ctrl.sv
// Directed plus randomized bench for rram_seq_ctrl; expectations come from
// per-transaction cycle arithmetic (operation, flag delay, readout length).
module tb_rram_seq_ctrl;

    localparam int T = 16384;

    logic clk, rst_n;
    logic cmd_form, cmd_write, cmd_read, cmd_release;
    logic forming_count_flag, write_count_flag, cache_count_flag;
    logic en, forming, we, re, WE_L, RE_L, busy, done, err;

    int errors = 0;
    int checks = 0;
    bit err_exp = 0;

    rram_seq_ctrl #(.TIMEOUT_CYCLES(T), .TW(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_form(cmd_form), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_release(cmd_release),
        .forming_count_flag(forming_count_flag), .write_count_flag(write_count_flag),
        .cache_count_flag(cache_count_flag),
        .en(en), .forming(forming), .we(we), .re(re), .WE_L(WE_L), .RE_L(RE_L),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_form = 0; cmd_write = 0; cmd_read = 0; cmd_release = 0;
        forming_count_flag = 0; write_count_flag = 0; cache_count_flag = 0;
    endtask

    // Observed/expected vectors are {en,forming,we,re,WE_L,RE_L,busy,done,err}
    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {en, forming, we, re, WE_L, RE_L, busy, done, err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] op_vec(input int op);
        case (op)
            0:       return 9'b1_1000_0_1_0_0;  // FORM
            1:       return 9'b1_0100_0_1_0_0;  // WRITE
            default: return 9'b1_0011_0_1_0_0;  // READ
        endcase
    endfunction

    // op: 0 form, 1 write, 2 read. Matching flag rises in the len-th strobe
    // cycle; a read then spends outlen cycles in readout before release.
    task automatic run_op(input int op, input int len, input int outlen,
                          input bit noise, input bit both);
        cmd_form  = (op == 0);
        cmd_write = (op == 1) || (both && op < 1);
        cmd_read  = (op == 2) || (both && op < 2);
        tick();
        clear_inputs();
        err_exp = 0;
        for (int k = 1; k <= len; k++) begin
            chk($sformatf("op%0d_strobe_k%0d", op, k), op_vec(op));
            if (noise) begin
                cmd_form    = ($urandom_range(0, 7) == 0);
                cmd_write   = ($urandom_range(0, 7) == 0);
                cmd_read    = ($urandom_range(0, 7) == 0);
                cmd_release = ($urandom_range(0, 7) == 0);
                forming_count_flag = (op != 0) && ($urandom_range(0, 3) == 0);
                write_count_flag   = (op != 1) && ($urandom_range(0, 3) == 0);
                cache_count_flag   = (op != 2) && ($urandom_range(0, 3) == 0);
            end
            case (op)
                0:       forming_count_flag = (k == len);
                1:       write_count_flag   = (k == len);
                default: cache_count_flag   = (k == len);
            endcase
            tick();
            clear_inputs();
        end
        if (op == 2) begin
            for (int j = 1; j <= outlen; j++) begin
                chk($sformatf("out_j%0d", j), 9'b1_0000_1_1_0_0);
                if (noise) begin
                    cmd_form           = ($urandom_range(0, 7) == 0);
                    cmd_write          = ($urandom_range(0, 7) == 0);
                    cmd_read           = ($urandom_range(0, 7) == 0);
                    forming_count_flag = ($urandom_range(0, 3) == 0);
                    write_count_flag   = ($urandom_range(0, 3) == 0);
                    cache_count_flag   = ($urandom_range(0, 3) == 0);
                end
                cmd_release = (j == outlen);
                tick();
                clear_inputs();
            end
        end
        chk($sformatf("op%0d_fin", op), 9'b1_0000_0_1_1_0);
        tick();
        chk($sformatf("op%0d_idle", op), 9'b0_0000_0_0_0_0);
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #3;
        chk("reset_state", 9'b0);
        tick();
        rst_n = 1;
        tick();
        chk("idle_after_reset", 9'b0);
        cmd_release = 1;
        tick();
        clear_inputs();
        chk("release_in_idle_ignored", 9'b0);

        // Forming: 4096 strobe cycles
        run_op(0, 4096, 0, 0, 0);
        // Write: exactly 32 strobe cycles
        run_op(1, 32, 0, 0, 0);
        // Read + 100 cycles of readout without release
        run_op(2, 32, 101, 0, 0);
        // Priority: form with write and read together
        run_op(0, 5, 0, 0, 1);
        // Priority: write with read together
        run_op(1, 3, 0, 0, 1);
        // Commands during form ignored; no read afterwards
        run_op(0, 20, 0, 1, 0);
        tick();
        chk("no_read_after_fin", 9'b0);
        // Flag coincident with timeout: done, not err
        run_op(0, T, 0, 0, 0);
        // Flag one cycle immediately after accept
        run_op(1, 1, 0, 0, 0);

        // Timeout on write
        cmd_write = 1;
        tick();
        clear_inputs();
        for (int k = 1; k <= T; k++) begin
            chk("timeout_write_strobe", op_vec(1));
            cmd_read = ($urandom_range(0, 15) == 0);
            tick();
            clear_inputs();
        end
        chk("timeout_err_state", 9'b0_0000_0_1_0_1);
        tick();
        err_exp = 1;
        chk("timeout_idle_err_sticky", 9'b0_0000_0_0_0_1);
        tick();
        chk("timeout_err_still_sticky", {8'b0, err_exp});
        // cmd_read clears err
        run_op(2, 4, 2, 0, 0);

        // Async reset mid-write
        cmd_write = 1;
        tick();
        clear_inputs();
        chk("pre_reset_write", op_vec(1));
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_drop", 9'b0);
        #2;
        rst_n = 1;
        tick();
        chk("idle_after_async_reset", 9'b0);
        run_op(2, 32, 3, 0, 0);

        // Randomized back-to-back traffic
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 2);
            run_op(op, $urandom_range(1, 40), $urandom_range(1, 20),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
